// File: rtl/mips_harvard_data_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mips_harvard_data_ram                                          |
// | Brief   : Data RAM for a Harvard MIPS core; wait states when the macro   |
// |           DATA_RAM_WAIT_STATE_EN is defined, otherwise zero-wait.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_harvard_data_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h00001000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic        addr_error,
  output logic [15:0] access_count
);

  localparam int c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [15:0]        r_access_count;
  logic               r_addr_error;

  logic [31:0]        w_offset;
  logic [29:0]        w_word;
  logic [c_idx_w-1:0] w_index;
  logic               w_in_range;
  logic               w_req;
  logic               w_commit;
  logic               w_unused_bits;

  // Subtracting the base first makes addresses below it wrap high, so a
  // single unsigned compare rejects both sides of the window.
  assign w_offset      = data_address - BASE_ADDR;
  assign w_word        = w_offset[31:2];
  assign w_index       = w_word[c_idx_w-1:0];
  assign w_in_range    = (w_word < 30'(DEPTH_WORDS));
  assign w_unused_bits = ^w_offset[1:0];

  assign w_req    = data_read | data_write;
  assign w_commit = clk_enable & w_req & ~reset;

  assign data_readdata = (data_read && w_in_range) ? r_mem[w_index] : 32'h0;

  always_ff @(posedge clk) begin
    if (w_commit && data_write && w_in_range) begin
      r_mem[w_index] <= data_writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_access_count <= 16'd0;
      r_addr_error   <= 1'b0;
    end else if (w_commit) begin
      if (w_in_range) begin
        r_access_count <= r_access_count + 16'd1;
      end
      if (!w_in_range || (data_read && data_write)) begin
        r_addr_error <= 1'b1;
      end
    end
  end

  assign access_count = r_access_count;
  assign addr_error   = r_addr_error;

`ifdef DATA_RAM_WAIT_STATE_EN
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam bit         c_has_wait  = (WAIT_CYCLES > 0);
  localparam logic [3:0] c_wait_load = c_has_wait ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t     r_state;
  logic [3:0] r_cnt;

  always_comb begin
    clk_enable = 1'b1;
    if (!reset) begin
      if (r_state == ST_IDLE) begin
        clk_enable = !(w_req && c_has_wait);
      end else begin
        clk_enable = (r_cnt == 4'd0);
      end
    end
  end

  // Once stalled the countdown ignores req; only the final cycle commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && c_has_wait) begin
            r_state <= ST_STALL;
            r_cnt   <= c_wait_load;
          end
        end
        ST_STALL: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end
`else
  localparam int c_unused_wait = WAIT_CYCLES;

  assign clk_enable = 1'b1;
`endif

endmodule
`default_nettype wire

// File: doc/mips_harvard_data_ram.md
MIPS_HARVARD_DATA_RAM -- requirements
Module: mips_harvard_data_ram

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h00001000, byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, 2..65536).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, stall cycles per access (0..15).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port data_address, input, 32, byte address from the CPU (bits [1:0] ignored).
REQ-007 The block SHALL have port data_write, input, 1, write request.
REQ-008 The block SHALL have port data_read, input, 1, read request.
REQ-009 The block SHALL have port data_writedata, input, 32, write data.
REQ-010 The block SHALL have port data_readdata, output, 32, combinational read data.
REQ-011 The block SHALL have port clk_enable, output, 1, CPU advance enable; 0 stalls the CPU.
REQ-012 The block SHALL have port addr_error, output, 1, sticky out-of-range or protocol-error flag.
REQ-013 The block SHALL have port access_count, output, 16, count of committed accesses.

Function
REQ-014 Word index SHALL be (data_address - BASE_ADDR) >> 2; the access is in range when 0 <= index < DEPTH_WORDS (unsigned compare; addresses below BASE_ADDR are out of range).
REQ-015 data_readdata SHALL equal mem[index] when data_read=1 and in range, else 32'h0, with zero cycle latency.
REQ-016 req SHALL be defined as data_read | data_write.
REQ-017 A write SHALL commit (mem[index] <= data_writedata) on a rising edge only when data_write=1, clk_enable=1, in range and reset=0.
REQ-018 The stall FSM SHALL have states IDLE and STALL plus a 4-bit down-counter cnt.
REQ-019 In IDLE, clk_enable SHALL be 0 if req=1 and WAIT_CYCLES>0, else 1.
REQ-020 IDLE with req=1 and WAIT_CYCLES>0 SHALL go to STALL, loading cnt=WAIT_CYCLES-1.
REQ-021 In STALL, clk_enable SHALL be 1 when cnt=0, else 0; cnt SHALL decrement while nonzero.
REQ-022 STALL with cnt=0 SHALL return to IDLE on the next edge.
REQ-023 Each access SHALL therefore see exactly WAIT_CYCLES cycles with clk_enable=0 followed by one cycle with clk_enable=1.
REQ-024 Once in STALL, the stall SHALL run to completion even if req drops; commit/count SHALL use the inputs of the final (clk_enable=1) cycle only.
REQ-025 Back-to-back requests SHALL restart the stall from IDLE with no idle gap.
REQ-026 access_count SHALL increment by 1, wrapping 16'hFFFF to 0, on each edge where clk_enable=1, req=1, and the access is in range.
REQ-027 addr_error SHALL set on an edge where clk_enable=1, req=1, and either the access is out of range or data_read and data_write are both 1; it SHALL clear only on reset.
REQ-028 When data_read and data_write are both 1 and in range, the write SHALL commit and data_readdata SHALL show the pre-write word.

Reset
REQ-029 Reset SHALL force state=IDLE, cnt=0, addr_error=0 and access_count=0 on the next edge, overriding any stall in progress.
REQ-030 While reset=1, clk_enable SHALL be 1 and no write SHALL commit.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With macro DATA_RAM_WAIT_STATE_EN defined, the stall FSM SHALL be built as in REQ-018..REQ-025.
REQ-033 Without DATA_RAM_WAIT_STATE_EN, the FSM and counter SHALL be omitted, clk_enable SHALL be constant 1, and WAIT_CYCLES SHALL be ignored; all other behaviour SHALL be unchanged.

Verification
REQ-034 Setup: WAIT_CYCLES=2, macro defined. Stimulus: write 32'hDEADBEEF to 32'h00001008, then read 32'h00001008. Required: clk_enable reads 0,0,1 per access; readdata=32'hDEADBEEF; access_count=2.
REQ-035 Stimulus: read 32'h00000FFC and write 32'h00002000 (DEPTH_WORDS=1024). Required: readdata=0, no memory change, addr_error=1 after the commit edge, access_count unchanged.
REQ-036 Stimulus: reset asserted in the second stall cycle of a write. Required: clk_enable=1 during reset, no commit, state IDLE, counters 0.
REQ-037 Stimulus: data_read=data_write=1 at 32'h00001000, old word 32'h1, write 32'h2. Required: readdata=32'h1 before the commit, mem=32'h2 after it, addr_error=1.
REQ-038 Stimulus: 65537 committed reads. Required: access_count=1.
REQ-039 Setup: macro undefined. Stimulus: write 32'h5 then read it back. Required: clk_enable constantly 1, readdata=32'h5 in the cycle after the write.
